pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline. Holds the PC and drives the instruction-memory address.
//  Selects next PC from PC+4, a taken-branch target, or the 32-bit jump target made by the ID-stage jump extender.
//  Captures the fetched word into the IF/ID pipeline register with stall and flush control.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR     32'h0000_0000  word loaded into if_id_instr on bubble (sll $0,$0,0)
// PORTS
//  clock          in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high
//  stall          in   1   hazard unit: hold PC and IF/ID
//  flush          in   1   bubble IF/ID next edge
//  jump           in   1   ID decodes J/JAL this cycle
//  jump_addr      in   32  zero-extended 26-bit jump field from ID
//  branch_taken   in   1   branch resolved taken (later stage)
//  branch_target  in   32  byte address of branch target
//  imem_addr      out  32  instruction-memory address (= pc, combinational)
//  imem_data      in   32  instruction word, combinational read of imem_addr
//  pc             out  32  current PC
//  if_id_instr    out  32  IF/ID instruction
//  if_id_pc4      out  32  IF/ID PC+4
//  if_id_valid    out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset, including mid-operation: pc=RESET_VECTOR, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0.
//    First real fetch comes on the first edge after reset drops.
//  - pc_plus4 = pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
//  - Next-PC priority, highest first:
//      1. branch_taken -> branch_target. Overrides stall; the branch is older.
//      2. stall        -> pc held.
//      3. jump         -> jump target (see CONFIGURATION).
//      4. default      -> pc_plus4.
//  - Every value loaded into pc has bits [1:0] forced to 2'b00.
//  - IF/ID priority, highest first:
//      1. flush, branch_taken, or (jump & !stall) -> instr=NOP_INSTR, pc4=0, valid=0.
//      2. stall -> hold all IF/ID fields.
//      3. else  -> instr=imem_data, pc4=pc_plus4, valid=1.
//  - Latency: redirect sampled at edge N puts the target in pc after edge N.
//    The target's instruction is in IF/ID after edge N+1. A redirect costs 1 bubble.
//  - flush together with stall: the flush wins; PC is still held.
//  - Outputs are registered except imem_addr, which equals pc.
// CONFIGURATION
//  Macro JUMP_REGION_EN.
//   Defined:   jump target = {pc_plus4[31:28], jump_addr[25:0], 2'b00}. MIPS J semantics.
//   Undefined: jump target = {jump_addr[29:0], 2'b00}. Flat word-index addressing.
//              jump_addr[31:26] are zero from the extender.
// STRUCTURE
//  - Shared package mips_pkg:
//      RESET_VECTOR default
//      NOP_INSTR
//      2-bit next-PC select encoding: NPC_SEQ, NPC_HOLD, NPC_JUMP, NPC_BRANCH
//      PC width constant (32)
//  - Sub-module if_id_reg: the IF/ID register with stall/flush.
//    The top level keeps the PC register and next-PC mux.
// TESTING
//  1. reset high, then low with imem_data=32'h2008_0005:
//     pc 0 -> 4 -> 8; if_id_instr=32'h2008_0005, if_id_pc4=4, valid=1.
//  2. jump=1, jump_addr=32'h0000_0040 at pc=8:
//     next pc=32'h0000_0100; IF/ID bubble (valid=0, instr=0).
//     Same result with or without JUMP_REGION_EN when pc_plus4[31:28]=0.
//  3. stall=1 for 3 cycles at pc=32'h10:
//     pc stays 32'h10 and IF/ID is unchanged; both resume the cycle after stall drops.
//  4. stall=1, branch_taken=1, branch_target=32'h0000_0203 together:
//     pc=32'h0000_0200 (low bits cleared); IF/ID bubbled.
//  5. pc=32'hFFFF_FFFC, no control:
//     next pc=0; if_id_pc4=0, valid=1.
//     With JUMP_REGION_EN, pc=32'hA000_0000 and jump_addr=32'h10 -> pc=32'hA000_0040.
//  6. reset asserted mid-stream while stall=1:
//     pc=RESET_VECTOR and valid=0 at once, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS pipeline front end
package mips_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0]     NOP_INSTR_DEF    = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_HOLD   = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_BRANCH = 2'b11
  } npc_sel_e;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; bubble beats stall, stall holds
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            bubble,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc4_in,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] pc4_out,
  output logic            valid_out
);

  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc4;
  logic            r_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (bubble) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_instr <= instr_in;
      r_pc4   <= pc4_in;
      r_valid <= 1'b1;
    end
  end

  assign instr_out = r_instr;
  assign pc4_out   = r_pc4;
  assign valid_out = r_valid;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF stage: PC register, next-PC select, IF/ID capture
// JUMP_REGION_EN selects MIPS region-relative jump targets instead of flat word-index jumps.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0]     NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            jump,
  input  logic [31:0]     jump_addr,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc4,
  output logic            if_id_valid
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_jump_target;
  logic [PC_W-1:0] w_next_pc;
  npc_sel_e        w_npc_sel;
  logic            w_bubble;
  logic            w_unused;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef JUMP_REGION_EN
  assign w_jump_target = {w_pc_plus4[31:28], jump_addr[25:0], 2'b00};
  assign w_unused      = ^jump_addr[31:26];
`else
  assign w_jump_target = {jump_addr[29:0], 2'b00};
  assign w_unused      = ^jump_addr[31:30];
`endif

  // A resolved branch is older than whatever caused the stall, so it wins.
  always_comb begin
    w_npc_sel = NPC_SEQ;
    if (branch_taken)
      w_npc_sel = NPC_BRANCH;
    else if (stall)
      w_npc_sel = NPC_HOLD;
    else if (jump)
      w_npc_sel = NPC_JUMP;
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_npc_sel)
      NPC_BRANCH: w_next_pc = branch_target;
      NPC_HOLD:   w_next_pc = r_pc;
      NPC_JUMP:   w_next_pc = w_jump_target;
      default:    w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_pc <= word_align(RESET_VECTOR);
    else
      r_pc <= word_align(w_next_pc);
  end

  // The word fetched alongside a redirect is on the wrong path.
  assign w_bubble = flush | branch_taken | (jump & ~stall);

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clock    (clock),
    .reset    (reset),
    .stall    (stall),
    .bubble   (w_bubble),
    .instr_in (imem_data),
    .pc4_in   (w_pc_plus4),
    .instr_out(if_id_instr),
    .pc4_out  (if_id_pc4),
    .valid_out(if_id_valid)
  );

  assign pc        = r_pc;
  assign imem_addr = r_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        jump;
  logic [31:0] jump_addr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int n_pass  = 0;
  int n_total = 0;

  pc_fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   if_id_pc4,   pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; jump = 1'b0; jump_addr = '0;
    branch_taken = 1'b0; branch_target = '0; imem_data = 32'h2008_0005;
    #23;
    check("rst.pc", pc, 32'h0);
    check("rst.imem_addr", imem_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);

    // reset release and sequential fetch
    reset = 1'b0;
    tick();
    check("seq1.pc", pc, 32'h4);
    check_ifid("seq1", 32'h2008_0005, 32'h4, 1'b1);
    tick();
    check("seq2.pc", pc, 32'h8);
    check("seq2.imem_addr", imem_addr, 32'h8);
    check("seq2.pc4", if_id_pc4, 32'h8);

    // jump at pc=8
    jump = 1'b1; jump_addr = 32'h0000_0040;
    tick();
    jump = 1'b0;
    check("jmp.pc", pc, 32'h100);
    check_ifid("jmp", 32'h0, 32'h0, 1'b0);

    // branch to 0xC, then fetch to 0x10
    branch_taken = 1'b1; branch_target = 32'h0000_000C;
    tick();
    branch_taken = 1'b0;
    check("br.pc", pc, 32'hC);
    imem_data = 32'h1111_1111;
    tick();
    check("pre_stall.pc", pc, 32'h10);
    check_ifid("pre_stall", 32'h1111_1111, 32'h10, 1'b1);

    // three-cycle stall at pc=0x10
    stall = 1'b1; imem_data = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.pc", pc, 32'h10);
      check_ifid("stall", 32'h1111_1111, 32'h10, 1'b1);
    end
    stall = 1'b0;
    tick();
    check("resume.pc", pc, 32'h14);
    check_ifid("resume", 32'h2222_2222, 32'h14, 1'b1);

    // flush with stall: PC held, IF/ID bubbled
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    check("flush_stall.pc", pc, 32'h14);
    check_ifid("flush_stall", 32'h0, 32'h0, 1'b0);

    // branch overrides stall, target low bits cleared
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0203;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    check("br_stall.pc", pc, 32'h200);
    check_ifid("br_stall", 32'h0, 32'h0, 1'b0);

    // wrap from 0xFFFF_FFFC
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("wrap_pre.pc", pc, 32'hFFFF_FFFC);
    imem_data = 32'h3333_3333;
    tick();
    check("wrap.pc", pc, 32'h0);
    check_ifid("wrap", 32'h3333_3333, 32'h0, 1'b1);

    // jump under stall: stall wins, IF/ID held
    stall = 1'b1; jump = 1'b1; jump_addr = 32'h0000_0080;
    tick();
    stall = 1'b0; jump = 1'b0;
    check("jmp_stall.pc", pc, 32'h0);
    check_ifid("jmp_stall", 32'h3333_3333, 32'h0, 1'b1);

`ifdef JUMP_REGION_EN
    branch_taken = 1'b1; branch_target = 32'hA000_0000;
    tick();
    branch_taken = 1'b0;
    jump = 1'b1; jump_addr = 32'h0000_0010;
    tick();
    jump = 1'b0;
    check("jmp_region.pc", pc, 32'hA000_0040);
`endif

    // asynchronous reset mid-stream while stalled
    imem_data = 32'h4444_4444;
    tick();
    check("pre_rst.valid", {31'd0, if_id_valid}, 32'h1);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.pc", pc, 32'h0);
    check("async_rst.imem_addr", imem_addr, 32'h0);
    check_ifid("async_rst", 32'h0, 32'h0, 1'b0);
    tick();
    check("rst_hold.pc", pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
